// File: rtl/y_coordinate_scan_read.sv
// y_coordinate_scan_read: snapshots a packed board row and streams each point with its y
// over valid/ready, flagging the first WIN_LEN run of same-colour stones.
module y_coordinate_scan_read #(
    parameter int POINTS  = 16,
    parameter int INFO_W  = 2,
    parameter int WIN_LEN = 5,
    localparam int YW = $clog2(POINTS),
    localparam int RW = $clog2(POINTS + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [POINTS*INFO_W-1:0] row_in,
    input  logic                     start,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INFO_W-1:0]        out_info,
    output logic [YW-1:0]            out_y,
    output logic                     out_last,
    output logic                     done,
    output logic                     win_found,
    output logic [INFO_W-1:0]        win_color,
    output logic [YW-1:0]            win_end_y
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                   state, state_next;
    logic [POINTS*INFO_W-1:0] snap;
    logic [YW-1:0]            y;
    logic [RW-1:0]            run, run_next;
    logic [INFO_W-1:0]        prev, info;
    logic                     accept, is_color, last, launch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state == IDLE ? (start ? SCAN : IDLE)
                   : state == SCAN ? (accept && last ? DONE : SCAN)
                   : IDLE;
        launch     = state == IDLE && start;
        info       = snap[y*INFO_W +: INFO_W];
        last       = y == YW'(POINTS - 1);
        out_valid  = state == SCAN;
        busy       = state != IDLE;
        done       = state == DONE;
        accept     = out_valid && out_ready;
        out_info   = out_valid ? info : '0;
        out_y      = out_valid ? y : '0;
        out_last   = out_valid && last;
        // reserved code 11 and empty both break a run
        is_color   = info == INFO_W'(1) || info == INFO_W'(2);
        run_next   = !is_color ? '0
                   : info != prev ? RW'(1)
                   : run == RW'(POINTS) ? run : run + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            snap      <= '0;
            y         <= '0;
            run       <= '0;
            prev      <= '0;
            win_found <= 1'b0;
            win_color <= '0;
            win_end_y <= '0;
        end else if (launch) begin
            snap      <= row_in;
            y         <= '0;
            run       <= '0;
            prev      <= '0;
            win_found <= 1'b0;
            win_color <= '0;
            win_end_y <= '0;
        end else if (accept) begin
            if (!last) y <= y + 1'b1;
            run  <= run_next;
            prev <= info;
            if (!win_found && run_next == RW'(WIN_LEN)) begin
                win_found <= 1'b1;
                win_color <= info;
                win_end_y <= y;
            end
        end
    end
endmodule

// File: tb/tb_y_coordinate_scan_read.sv
// tb_y_coordinate_scan_read: table-driven row scans with hand-computed win results,
// plus hand-written sequences for mid-scan reset and start-while-busy.
module tb_y_coordinate_scan_read;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] row_in;
    logic        start;
    logic        busy, out_valid, out_ready, out_last, done, win_found;
    logic [1:0]  out_info, win_color;
    logic [3:0]  out_y, win_end_y;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] row;
        bit          stall;
        bit          pulse;
        bit          found;
        logic [1:0]  color;
        int          end_y;
    } vec_t;

    vec_t v[8];

    y_coordinate_scan_read dut (
        .clock(clock), .reset(reset), .row_in(row_in), .start(start), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .out_info(out_info), .out_y(out_y),
        .out_last(out_last), .done(done), .win_found(win_found), .win_color(win_color),
        .win_end_y(win_end_y)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] put(input logic [31:0] r, input int lo, input int hi,
                                        input logic [1:0] c);
        logic [31:0] t;
        t = r;
        for (int i = lo; i <= hi; i++) t[2*i +: 2] = c;
        return t;
    endfunction

    // Full scan of one vector; row_in is inverted after the start edge so only the snapshot can match.
    task automatic scan(input vec_t t);
        logic [3:0] pat;
        logic [31:0] r;
        int ey, acc, k;
        bit rdy;
        pat = 4'b1001;
        r   = t.row;
        @(negedge clock);
        row_in = r;
        start  = 1'b1;
        @(negedge clock);
        start  = t.pulse;
        row_in = ~r;
        ey  = 0;
        acc = 0;
        for (k = 0; k < 200 && acc < 16; k++) begin
            check("valid", out_valid, 1);
            check("busy", busy, 1);
            check("y", out_y, ey);
            check("info", out_info, r[2*ey +: 2]);
            check("last", out_last, ey == 15);
            check("done_low", done, 0);
            check("win_timing", win_found, t.found && acc > t.end_y);
            rdy = t.stall ? pat[k % 4] : 1'b1;
            out_ready = rdy;
            @(negedge clock);
            if (rdy) begin
                acc++;
                if (ey < 15) ey++;
            end
        end
        out_ready = 1'b1;
        check("accepts", acc, 16);
        check("cycles", k, t.stall ? 32 : 16);
        check("done_pulse", done, 1);
        check("valid_in_done", out_valid, 0);
        check("busy_in_done", busy, 1);
        @(negedge clock);
        start = 1'b0;
        check("done_cleared", done, 0);
        check("busy_idle", busy, 0);
        @(negedge clock);
        check("no_relaunch", busy, 0);
        check("win_found", win_found, t.found);
        check("win_color", win_color, t.found ? t.color : 2'b00);
        check("win_end_y", win_end_y, t.found ? t.end_y : 0);
    endtask

    initial begin
        v[0] = '{32'h0, 0, 0, 0, 2'b00, 0};
        v[1] = '{put(0, 3, 7, 2'b01), 0, 0, 1, 2'b01, 7};
        v[2] = '{put(put(put(0, 0, 3, 2'b10), 4, 4, 2'b11), 5, 9, 2'b10), 0, 0, 1, 2'b10, 9};
        v[3] = '{put(0, 10, 15, 2'b10), 1, 0, 1, 2'b10, 14};
        v[4] = '{put(0, 0, 6, 2'b01), 0, 1, 1, 2'b01, 4};
        v[5] = '{put(put(0, 0, 3, 2'b01), 4, 8, 2'b10), 0, 0, 1, 2'b10, 8};
        v[6] = '{32'h5569_9999, 0, 0, 1, 2'b01, 15};
        v[7] = '{32'hFFFF_FFFF, 1, 1, 0, 2'b00, 0};

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        row_in = 32'hFFFF_FFFF;
        repeat (2) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_done", done, 0);
        check("rst_y", out_y, 0);
        check("rst_info", out_info, 0);
        check("rst_win", win_found, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) scan(v[i]);

        // Reset while beat y=8 is presented
        @(negedge clock);
        row_in = v[1].row;
        start  = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (8) @(negedge clock);
        check("pre_reset_y", out_y, 8);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_y", out_y, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_win", win_found, 0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("no_done_after_rst", done, 0);
            check("idle_after_rst", busy, 0);
        end
        scan(v[1]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
